// File: rtl/spi_pkg.sv
// ============================================================================
// Module      : spi_pkg
// Description : Shared widths and FSM state encoding for the SPI frame master.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_pkg;

    localparam int SPI_CMD_W   = 8;
    localparam int SPI_DATA_W  = 32;
    localparam int SPI_FRAME_W = SPI_CMD_W + SPI_DATA_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } spi_state_e;

endpackage

`default_nettype wire

// File: rtl/spi_clk_gen.sv
// ============================================================================
// Module      : spi_clk_gen
// Description : sck half-period divider with rise/fall strobes on wrap cycles.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic nrst,
    input  logic en,
    input  logic stop,
    output logic rise,
    output logic fall,
    output logic sck
);

    localparam int CNT_W = $clog2(CLK_DIV);

    logic [CNT_W-1:0] r_cnt;
    logic             r_sck;
    logic             w_wrap;

    assign w_wrap = en && (r_cnt == CNT_W'(CLK_DIV - 1));
    assign rise   = w_wrap && !r_sck;
    assign fall   = w_wrap && r_sck;
    assign sck    = r_sck;

    // stop keeps sck low across the strobe that closes the final low phase
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_cnt <= '0;
            r_sck <= 1'b0;
        end else if (!en) begin
            r_cnt <= '0;
            r_sck <= 1'b0;
        end else if (w_wrap) begin
            r_cnt <= '0;
            r_sck <= stop ? 1'b0 : ~r_sck;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/spi_frame_master.sv
// ============================================================================
// Module      : spi_frame_master
// Description : Two-requester round-robin SPI mode-0 master, cmd+data frames.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_frame_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 4,
    parameter int CMD_W   = SPI_CMD_W,
    parameter int DATA_W  = SPI_DATA_W
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              rq0_valid,
    input  logic [CMD_W-1:0]  rq0_cmd,
    input  logic [DATA_W-1:0] rq0_data,
    output logic              rq0_ack,
    input  logic              rq1_valid,
    input  logic [CMD_W-1:0]  rq1_cmd,
    input  logic [DATA_W-1:0] rq1_data,
    output logic              rq1_ack,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [CMD_W-1:0]  rsp_stat,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              sck,
    output logic              mosi,
    output logic              ncs,
    input  logic              miso
);

    localparam int FRAME_W = CMD_W + DATA_W;
    localparam int BIT_W   = $clog2(FRAME_W + 1);
    localparam int GAP_W   = $clog2(CS_GAP + 1);

    if (CLK_DIV < 4) begin : g_bad_clk_div
        $error("spi_frame_master: CLK_DIV must be >= 4");
    end
    if (CS_GAP < 1) begin : g_bad_cs_gap
        $error("spi_frame_master: CS_GAP must be >= 1");
    end

    spi_state_e         r_state;
    logic [FRAME_W-1:0] r_shift;
    logic [FRAME_W-1:0] r_rx;
    logic               r_id;
    logic               r_pref;
    logic [BIT_W-1:0]   r_bit_cnt;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic               r_clk_en;
    logic               w_rise;
    logic               w_fall;
    logic               w_stop;
    logic               w_grant_id;

    // r_pref names the requester that wins a tie
    assign w_grant_id = (rq0_valid && rq1_valid) ? r_pref : rq1_valid;
    assign w_stop     = (r_state == SHIFT) && (r_bit_cnt == BIT_W'(FRAME_W));

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk  (clk),
        .nrst (nrst),
        .en   (r_clk_en),
        .stop (w_stop),
        .rise (w_rise),
        .fall (w_fall),
        .sck  (sck)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_rx      <= '0;
            r_id      <= 1'b0;
            r_pref    <= 1'b0;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
            r_clk_en  <= 1'b0;
            rq0_ack   <= 1'b0;
            rq1_ack   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_stat  <= '0;
            rsp_data  <= '0;
            busy      <= 1'b0;
            mosi      <= 1'b0;
            ncs       <= 1'b1;
        end else begin
            rq0_ack   <= 1'b0;
            rq1_ack   <= 1'b0;
            rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (rq0_valid || rq1_valid) begin
                        r_id    <= w_grant_id;
                        r_pref  <= ~w_grant_id;
                        r_shift <= w_grant_id ? {rq1_cmd, rq1_data} : {rq0_cmd, rq0_data};
                        rq0_ack <= ~w_grant_id;
                        rq1_ack <= w_grant_id;
                        busy    <= 1'b1;
                        r_state <= SETUP;
                    end
                end
                SETUP: begin
                    // first SETUP cycle drops ncs; the divider then times the setup half-period
                    if (!r_clk_en) begin
                        ncs       <= 1'b0;
                        mosi      <= r_shift[FRAME_W-1];
                        r_clk_en  <= 1'b1;
                        r_bit_cnt <= '0;
                    end else if (w_rise) begin
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_fall) begin
                        r_rx      <= {r_rx[FRAME_W-2:0], miso};
                        r_shift   <= {r_shift[FRAME_W-2:0], 1'b0};
                        mosi      <= r_shift[FRAME_W-2];
                        r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                    end else if (w_rise && w_stop) begin
                        ncs       <= 1'b1;
                        mosi      <= 1'b0;
                        r_clk_en  <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_id    <= r_id;
                        rsp_stat  <= r_rx[FRAME_W-1:DATA_W];
                        rsp_data  <= r_rx[DATA_W-1:0];
                        r_gap_cnt <= '0;
                        r_state   <= GAP;
                    end
                end
                GAP: begin
                    if (r_gap_cnt == GAP_W'(CS_GAP - 1)) begin
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_spi_frame_master.sv
// ============================================================================
// Module      : tb_spi_frame_master
// Description : Self-checking bench with an SPI slave model and frame scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_frame_master;

    localparam int CLK_DIV = 4;
    localparam int CS_GAP  = 4;
    localparam int LAT     = CLK_DIV * 81 + 1;
    localparam int NCS_LOW = CLK_DIV * 81;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        rq0_valid = 1'b0, rq1_valid = 1'b0;
    logic [7:0]  rq0_cmd = '0, rq1_cmd = '0;
    logic [31:0] rq0_data = '0, rq1_data = '0;
    logic        rq0_ack, rq1_ack, rsp_valid, rsp_id, busy, sck, mosi, ncs;
    logic [7:0]  rsp_stat;
    logic [31:0] rsp_data;
    logic        miso = 1'b0;

    always #5 clk = ~clk;

    spi_frame_master #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP), .CMD_W(8), .DATA_W(32)) dut (
        .clk(clk), .nrst(nrst),
        .rq0_valid(rq0_valid), .rq0_cmd(rq0_cmd), .rq0_data(rq0_data), .rq0_ack(rq0_ack),
        .rq1_valid(rq1_valid), .rq1_cmd(rq1_cmd), .rq1_data(rq1_data), .rq1_ack(rq1_ack),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_stat(rsp_stat), .rsp_data(rsp_data),
        .busy(busy), .sck(sck), .mosi(mosi), .ncs(ncs), .miso(miso)
    );

    int checks = 0;
    int errors = 0;
    int reply_mode = 1;   // 0 random, 1 all ones, 2 all zeros

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model / scoreboard ----------------
    int unsigned cyc = 0;
    bit          prev_ok = 0, pv0 = 0, pv1 = 0, pbusy = 0;
    logic [39:0] pf0, pf1;
    bit          last_grant = 1;
    bit          have_frame = 0, f_id = 0;
    logic [39:0] f_frame, f_reply, mosi_cap;
    int unsigned f_ack_cyc = 0, last_rise_cyc = 0;
    int          rises = 0, low_cnt = 0;
    bit          seen_rise = 0, prev_ncs = 1, prev_sck = 0;
    logic [40:0] hold_rsp = '0;
    int          last_lat = 0, last_low = 0, last_rises = 0;
    logic [39:0] last_mosi = '0;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (!nrst) begin
            check_eq("reset ncs", ncs, 1);
            check_eq("reset sck/mosi", {sck, mosi}, 0);
            check_eq("reset acks/valid/busy", {rq0_ack, rq1_ack, rsp_valid, busy}, 0);
            check_eq("reset rsp fields", {rsp_id, rsp_stat, rsp_data}, 0);
            have_frame = 0; last_grant = 1; rises = 0; low_cnt = 0; seen_rise = 0;
            prev_ok = 0; prev_ncs = 1; prev_sck = 0; hold_rsp = '0;
        end else begin
            bit exp_ack, exp_id;
            exp_ack = prev_ok && !pbusy && (pv0 || pv1);
            exp_id  = (pv0 && pv1) ? !last_grant : pv1;
            check_eq("ack present", rq0_ack | rq1_ack, exp_ack);
            check_eq("ack onehot", rq0_ack & rq1_ack, 0);
            if (exp_ack && (rq0_ack ^ rq1_ack)) check_eq("ack id", rq1_ack, exp_id);
            if (rq0_ack || rq1_ack) begin
                check_eq("ack during frame", have_frame, 0);
                have_frame = 1; f_id = rq1_ack; f_frame = rq1_ack ? pf1 : pf0;
                f_ack_cyc = cyc; last_grant = rq1_ack;
            end
            if (prev_ncs && !ncs) begin
                logic [63:0] r;
                check_eq("ncs fall has frame", have_frame, 1);
                if (seen_rise) check_eq("cs gap", (cyc - last_rise_cyc) >= CS_GAP, 1);
                r = {$urandom(), $urandom()};
                f_reply = (reply_mode == 1) ? '1 : (reply_mode == 2) ? '0 : r[39:0];
                low_cnt = 0; rises = 0; mosi_cap = '0;
            end
            if (!ncs) low_cnt++;
            if (!prev_ncs && ncs) begin
                check_eq("ncs low cycles", low_cnt, NCS_LOW);
                last_low = low_cnt; last_rise_cyc = cyc; seen_rise = 1;
            end
            if (ncs) check_eq("idle sck/mosi", {sck, mosi}, 0);
            if (!ncs || have_frame) check_eq("busy in frame", busy, 1);
            if (!ncs && !prev_sck && sck) begin
                rises++;
                mosi_cap = {mosi_cap[38:0], mosi};
                miso = (rises <= 40) ? f_reply[40 - rises] : 1'b0;
            end else if (ncs) begin
                miso = 1'($urandom_range(0, 1));
            end
            if (rsp_valid) begin
                check_eq("rsp has frame", have_frame, 1);
                check_eq("rsp latency", cyc - f_ack_cyc, LAT);
                check_eq("rsp id", rsp_id, f_id);
                check_eq("rsp stat", rsp_stat, f_reply[39:32]);
                check_eq("rsp data", rsp_data, f_reply[31:0]);
                check_eq("mosi frame", mosi_cap, f_frame);
                check_eq("sck rises", rises, 40);
                hold_rsp = {rsp_id, rsp_stat, rsp_data};
                last_lat = int'(cyc - f_ack_cyc); last_rises = rises; last_mosi = mosi_cap;
                have_frame = 0;
            end else begin
                check_eq("rsp hold", {rsp_id, rsp_stat, rsp_data}, hold_rsp);
            end
            if (have_frame && (cyc - f_ack_cyc) > LAT + 10) begin
                check_eq("rsp timeout", 0, 1);
                have_frame = 0;
            end
            prev_ok = 1; pv0 = rq0_valid; pv1 = rq1_valid; pbusy = busy;
            pf0 = {rq0_cmd, rq0_data}; pf1 = {rq1_cmd, rq1_data};
            prev_ncs = ncs; prev_sck = sck;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit id, input logic [7:0] c, input logic [31:0] d);
        @(posedge clk); #1;
        if (id) begin rq1_valid = 1; rq1_cmd = c; rq1_data = d; end
        else    begin rq0_valid = 1; rq0_cmd = c; rq0_data = d; end
    endtask

    task automatic drop(input bit id);
        @(posedge clk); #1;
        if (id) rq1_valid = 0; else rq0_valid = 0;
    endtask

    task automatic wait_ack(input bit id, input string name);
        bit ok = 0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk);
            ok = id ? rq1_ack : rq0_ack;
        end
        check_eq(name, ok, 1);
    endtask

    task automatic wait_rsp(input string name);
        bit ok = 0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clk);
            ok = rsp_valid;
        end
        check_eq(name, ok, 1);
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 1000 && !ok; i++) begin
            @(negedge clk);
            ok = !busy;
        end
        check_eq("idle timeout", ok, 1);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        nrst = 0; rq0_valid = 0; rq1_valid = 0;
        repeat (3) @(posedge clk);
        #1 nrst = 1;
    endtask

    task automatic rand_requester(input bit id, input int n);
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 30)) @(posedge clk);
            drive(id, 8'($urandom()), $urandom());
            wait_ack(id, "random ack timeout");
            drop(id);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int ids[$];
        repeat (4) @(posedge clk);
        #1 nrst = 1;

        // single rq0 frame, miso tied high
        reply_mode = 1;
        drive(0, 8'hA0, 32'h24AF55AA);
        wait_ack(0, "t1 ack timeout");
        drop(0);
        wait_rsp("t1 rsp timeout");
        check_eq("t1 rsp_id", rsp_id, 0);
        check_eq("t1 rsp_stat", rsp_stat, 8'hFF);
        check_eq("t1 rsp_data", rsp_data, 32'hFFFFFFFF);
        @(negedge clk);
        check_eq("t1 mosi bits", last_mosi, 40'hA024AF55AA);
        check_eq("t1 ncs low", last_low, 324);
        check_eq("t1 latency", last_lat, 325);
        check_eq("t1 rises", last_rises, 40);
        wait_idle();

        // miso tied low
        reply_mode = 2;
        drive(0, 8'h55, 32'h01234567);
        wait_ack(0, "t2 ack timeout");
        drop(0);
        wait_rsp("t2 rsp timeout");
        check_eq("t2 rsp_stat", rsp_stat, 8'h00);
        check_eq("t2 rsp_data", rsp_data, 32'h00000000);
        @(negedge clk);
        check_eq("t2 mosi bits", last_mosi, 40'h5501234567);
        wait_idle();

        // simultaneous requests straight after reset, then held for four frames
        reply_mode = 0;
        do_reset();
        @(posedge clk); #1;
        rq0_valid = 1; rq0_cmd = 8'h11; rq0_data = 32'h11111111;
        rq1_valid = 1; rq1_cmd = 8'h22; rq1_data = 32'h22222222;
        for (int i = 0; i < 6000 && ids.size() < 6; i++) begin
            @(negedge clk);
            if (rq0_ack || rq1_ack) begin
                ids.push_back(rq1_ack ? 1 : 0);
                @(posedge clk); #1;
                if (rq1_ack) rq1_data = $urandom(); else rq0_data = $urandom();
            end
        end
        @(posedge clk); #1;
        rq0_valid = 0; rq1_valid = 0;
        check_eq("t3 ack count", ids.size(), 6);
        if (ids.size() == 6) begin
            check_eq("t3 first ack", ids[0], 0);
            check_eq("t3 second ack", ids[1], 1);
            check_eq("t4 ack order", {ids[2][0], ids[3][0], ids[4][0], ids[5][0]}, 4'b0101);
        end
        wait_idle();

        // reset in the middle of a frame
        drive(1, 8'h3C, $urandom());
        wait_ack(1, "t5 ack timeout");
        drop(1);
        begin
            int n = 0;
            bit ps = 0;
            for (int i = 0; i < 400 && n < 20; i++) begin
                @(negedge clk);
                if (sck && !ps) n++;
                ps = sck;
            end
            check_eq("t5 reached bit 20", n, 20);
        end
        @(posedge clk); #2;
        nrst = 0;
        #1;
        check_eq("t5 async ncs", ncs, 1);
        check_eq("t5 async sck", sck, 0);
        repeat (3) @(posedge clk);
        #1 nrst = 1;
        drive(0, 8'h5A, 32'hDEADBEEF);
        wait_ack(0, "t5 post ack timeout");
        drop(0);
        wait_rsp("t5 post rsp timeout");
        check_eq("t5 post rsp_id", rsp_id, 0);
        wait_idle();

        // randomized contention
        fork
            rand_requester(0, 8);
            rand_requester(1, 8);
        join
        wait_idle();
        repeat (10) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
